vespa_intc_param: RTL and testbench
===================================

Name: vespa_intc_param

Overview:
Parametrised successor to the VeSPA SoC's fixed 4-source interrupt controller. It accepts NUM_SRC asynchronous interrupt lines and synchronises them. Each line is configurable as level- or rising-edge-sensitive and has its own enable, plus a global enable. The block arbitrates by fixed priority, issues a single request/number to the CPU, and tracks one in-service interrupt through the CPU's attended/complete acknowledge pair.

Parameters:
NUM_SRC, 8, number of interrupt sources; legal range 2..32.
ID_W, $clog2(NUM_SRC), width of the source number.
SYNC_STAGES, 2, synchroniser flops per source; legal range 2..3.

Ports:
i_Clk  in  1  system clock.
i_Rst  in  1  asynchronous, active-high reset.
i_IntSources  in  NUM_SRC  raw interrupt lines, asynchronous.
i_GlobalEn  in  1  master enable; 0 blocks new requests.
i_SrcEn  in  NUM_SRC  per-source enable.
i_EdgeMode  in  NUM_SRC  1 = rising-edge latched, 0 = level.
i_IntAckAttended  in  1  CPU has vectored to the ISR (1-cycle pulse).
i_IntAckComplete  in  1  CPU has executed the ISR return (1-cycle pulse).
o_IntReq  out  1  interrupt request to the CPU.
o_IntNumber  out  ID_W  source id of the current request or in-service interrupt.
o_IntPending  out  1  another enabled source is pending besides the one requested or in service.
o_PendingVec  out  NUM_SRC  raw pending vector for debug.

Behaviour:
- Reset: all synchroniser flops, edge-pending bits, o_IntReq, o_IntNumber, o_IntPending and o_PendingVec are 0; FSM is in IDLE.
- Sync: each source passes through SYNC_STAGES flops. Edge detection compares the last sync stage with a delay flop.
- Pending, edge mode: a set-dominant latch. A detected rising edge sets the bit, and the bit clears on an attended pulse for that id. If an edge and the clear occur in the same cycle, the bit stays set.
- Pending, level mode: pending equals the synced level. There is no latch.
- Eligible = pending & i_SrcEn, gated by i_GlobalEn. Priority: the lowest index wins.
- FSM states are IDLE, REQ and SERVICE; transitions are registered.
  - IDLE: if any source is eligible, latch the winner into o_IntNumber, set o_IntReq=1 and go to REQ.
  - REQ: hold o_IntReq and o_IntNumber stable even if the source deasserts or is disabled; there is no request withdrawal. On i_IntAckAttended: o_IntReq=0, clear that id's edge-pending bit, go to SERVICE.
  - SERVICE: o_IntNumber is held. On i_IntAckComplete go to IDLE; a new arbitration can raise o_IntReq on the next cycle. There is no nesting: higher-priority sources wait.
- Ignored pulses: i_IntAckAttended outside REQ and i_IntAckComplete outside SERVICE.
- Simultaneous attended and complete in REQ: attended is taken and complete is ignored.
- Latency: o_IntReq rises SYNC_STAGES+2 rising clock edges after the first edge that samples the source high.
- o_IntPending: registered, and reflects eligible sources excluding the latched id while in REQ or SERVICE.
- Clearing i_GlobalEn or i_SrcEn does not abort REQ or SERVICE. A level source deasserted before attended still completes its handshake; the ISR handles the spurious case.

Optional Feature:
VESPA_INTC_ROUND_ROBIN_EN.
- Defined: arbitration is round-robin. A pointer register starts at 0 after reset. On attended it becomes (id+1) mod NUM_SRC, and the search begins at the pointer, wrapping around.
- Undefined: fixed lowest-index priority, and no pointer register is present.

Decomposition:
- Shared include vespa_intc_defines.vh holds the FSM state encodings (IDLE=2'd0, REQ=2'd1, SERVICE=2'd2) and the NUM_SRC limit checks.
- One sub-module, vespa_intc_arbiter: combinational priority/round-robin pick taking the eligible vector (plus the pointer when round-robin is enabled). It returns a valid flag and the winning id.

Test Plan:
- Reset mid-REQ: assert i_Rst while o_IntReq=1 -> o_IntReq, o_IntNumber and o_PendingVec go to 0 immediately, without waiting for a clock edge.
- Edge on src 5, all enabled: pulse i_IntSources[5] for 1 cycle -> o_IntReq=1 at edge 4 (SYNC_STAGES=2) with o_IntNumber=5. Attended -> o_IntReq=0; complete -> IDLE.
- Priority: sources 6 and 2 set as edge events in the same cycle -> o_IntNumber=2 with o_IntPending=1. After complete -> o_IntReq re-asserts with o_IntNumber=6.
- Level src 1 held high through complete -> o_IntReq re-asserts 1 cycle after complete with o_IntNumber=1. With i_SrcEn[1]=0 -> no request.
- Edge on src 3 in the same cycle as attended for id 3 -> pending bit stays set, and o_IntReq re-asserts after complete.
- VESPA_INTC_ROUND_ROBIN_EN with sources 0 and 1 level-high -> service order 0, 1, 0, 1.

Source files
------------

// File: rtl/vespa_intc_param_pkg.sv
// Shared types and limits for the parametrised VeSPA interrupt controller.
// Holds the FSM state encoding and the legal NUM_SRC / SYNC_STAGES ranges.
// The top and the arbiter both import this package.
package vespa_intc_param_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_REQ     = 2'd1,
        ST_SERVICE = 2'd2
    } intc_state_e;

    localparam int NUM_SRC_MIN     = 2;
    localparam int NUM_SRC_MAX     = 32;
    localparam int SYNC_STAGES_MIN = 2;
    localparam int SYNC_STAGES_MAX = 3;

endpackage

// File: rtl/vespa_intc_arbiter.sv
// Purpose: combinational pick of one eligible interrupt source.
// Latency: zero cycles, purely combinational.
// Backpressure: none; the caller decides when to use the pick.
// Ports: i_Elig eligible vector, i_Ptr search start (round-robin build only),
//        o_Vld any source eligible, o_Id winning source id.
// Build option: VESPA_INTC_ROUND_ROBIN_EN selects the rotating search.
module vespa_intc_arbiter
    import vespa_intc_param_pkg::*;
#(
    parameter int NUM_SRC = 8,
    parameter int ID_W    = $clog2(NUM_SRC)
) (
    input  logic [NUM_SRC-1:0] i_Elig,
`ifdef VESPA_INTC_ROUND_ROBIN_EN
    input  logic [ID_W-1:0]    i_Ptr,
`endif
    output logic               o_Vld,
    output logic [ID_W-1:0]    o_Id
);

`ifdef VESPA_INTC_ROUND_ROBIN_EN
    // Rotate the vector so the pointer position lands on bit 0, do a plain
    // lowest-index pick, then rotate the winning index back.
    logic [2*NUM_SRC-1:0] dbl;
    logic [NUM_SRC-1:0]   rot;
    int                   sum;

    always_comb begin
        dbl   = {i_Elig, i_Elig} >> i_Ptr;
        rot   = dbl[NUM_SRC-1:0];
        o_Vld = 1'b0;
        o_Id  = '0;
        sum   = 0;
        for (int k = NUM_SRC - 1; k >= 0; k--) begin
            if (rot[k]) begin
                o_Vld = 1'b1;
                sum   = k + int'(i_Ptr);
                if (sum >= NUM_SRC) begin
                    sum = sum - NUM_SRC;
                end
                o_Id  = ID_W'(sum);
            end
        end
    end
`else
    // Scan downwards so the lowest set index is the last one written.
    always_comb begin
        o_Vld = 1'b0;
        o_Id  = '0;
        for (int k = NUM_SRC - 1; k >= 0; k--) begin
            if (i_Elig[k]) begin
                o_Vld = 1'b1;
                o_Id  = ID_W'(k);
            end
        end
    end
`endif

endmodule

// File: rtl/vespa_intc_param.sv
// Purpose: NUM_SRC-source interrupt controller with sync, edge/level pending,
//          arbitration and a single in-service request/attend/complete handshake.
// Latency: o_IntReq rises SYNC_STAGES+2 edges after a source is first sampled high.
// Backpressure: one request at a time; other sources wait until complete.
// Ports: i_IntSources raw lines, i_GlobalEn/i_SrcEn enables, i_EdgeMode select,
//        i_IntAckAttended/i_IntAckComplete CPU pulses, o_IntReq/o_IntNumber request,
//        o_IntPending other-eligible flag, o_PendingVec debug pending vector.
// Build option: VESPA_INTC_ROUND_ROBIN_EN enables round-robin arbitration.
module vespa_intc_param
    import vespa_intc_param_pkg::*;
#(
    parameter int NUM_SRC     = 8,
    parameter int ID_W        = $clog2(NUM_SRC),
    parameter int SYNC_STAGES = 2
) (
    input  logic               i_Clk,
    input  logic               i_Rst,
    input  logic [NUM_SRC-1:0] i_IntSources,
    input  logic               i_GlobalEn,
    input  logic [NUM_SRC-1:0] i_SrcEn,
    input  logic [NUM_SRC-1:0] i_EdgeMode,
    input  logic               i_IntAckAttended,
    input  logic               i_IntAckComplete,
    output logic               o_IntReq,
    output logic [ID_W-1:0]    o_IntNumber,
    output logic               o_IntPending,
    output logic [NUM_SRC-1:0] o_PendingVec
);

    if (NUM_SRC < NUM_SRC_MIN || NUM_SRC > NUM_SRC_MAX) begin : g_bad_num_src
        $error("vespa_intc_param: NUM_SRC out of range 2..32");
    end
    if (SYNC_STAGES < SYNC_STAGES_MIN || SYNC_STAGES > SYNC_STAGES_MAX) begin : g_bad_sync
        $error("vespa_intc_param: SYNC_STAGES out of range 2..3");
    end

    logic [NUM_SRC-1:0] sync_q [SYNC_STAGES];
    logic [NUM_SRC-1:0] dly_q;
    logic [NUM_SRC-1:0] pend_q, pend_d;
    logic [NUM_SRC-1:0] synced, rise, elig, others;
    intc_state_e        state_q, state_d;
    logic               req_q, req_d;
    logic [ID_W-1:0]    num_q, num_d;
    logic               ip_q, ip_d;
    logic               att_clr;
    logic               arb_vld;
    logic [ID_W-1:0]    arb_id;

    assign synced = sync_q[SYNC_STAGES-1];
    assign rise   = synced & ~dly_q;
    assign elig   = i_GlobalEn ? (pend_q & i_SrcEn) : '0;

`ifdef VESPA_INTC_ROUND_ROBIN_EN
    logic [ID_W-1:0] ptr_q, ptr_d;

    always_comb begin
        ptr_d = ptr_q;
        if (att_clr) begin
            ptr_d = (num_q == ID_W'(NUM_SRC - 1)) ? '0 : num_q + 1'b1;
        end
    end

    always_ff @(posedge i_Clk or posedge i_Rst) begin
        if (i_Rst) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end
`endif

    vespa_intc_arbiter #(
        .NUM_SRC (NUM_SRC),
        .ID_W    (ID_W)
    ) u_arb (
        .i_Elig  (elig),
`ifdef VESPA_INTC_ROUND_ROBIN_EN
        .i_Ptr   (ptr_q),
`endif
        .o_Vld   (arb_vld),
        .o_Id    (arb_id)
    );

    always_comb begin
        state_d = state_q;
        req_d   = req_q;
        num_d   = num_q;
        att_clr = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (arb_vld) begin
                    num_d   = arb_id;
                    req_d   = 1'b1;
                    state_d = ST_REQ;
                end
            end
            ST_REQ: begin
                // Attended wins over a coincident complete.
                if (i_IntAckAttended) begin
                    req_d   = 1'b0;
                    att_clr = 1'b1;
                    state_d = ST_SERVICE;
                end
            end
            ST_SERVICE: begin
                if (i_IntAckComplete) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
                req_d   = 1'b0;
            end
        endcase
    end

    // Edge bits are set-dominant latches; level bits just follow the synced line.
    always_comb begin
        pend_d = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (i_EdgeMode[i]) begin
                pend_d[i] = rise[i] | (pend_q[i] & ~(att_clr && (num_q == ID_W'(i))));
            end else begin
                pend_d[i] = synced[i];
            end
        end
    end

    // Aligned with the next request/number so it is valid in the same cycle.
    always_comb begin
        others = elig & ~(NUM_SRC'(1) << num_d);
        ip_d   = (state_d != ST_IDLE) && (|others);
    end

    always_ff @(posedge i_Clk or posedge i_Rst) begin
        if (i_Rst) begin
            for (int k = 0; k < SYNC_STAGES; k++) begin
                sync_q[k] <= '0;
            end
            dly_q   <= '0;
            pend_q  <= '0;
            state_q <= ST_IDLE;
            req_q   <= 1'b0;
            num_q   <= '0;
            ip_q    <= 1'b0;
        end else begin
            sync_q[0] <= i_IntSources;
            for (int k = 1; k < SYNC_STAGES; k++) begin
                sync_q[k] <= sync_q[k-1];
            end
            dly_q   <= synced;
            pend_q  <= pend_d;
            state_q <= state_d;
            req_q   <= req_d;
            num_q   <= num_d;
            ip_q    <= ip_d;
        end
    end

    assign o_IntReq     = req_q;
    assign o_IntNumber  = num_q;
    assign o_IntPending = ip_q;
    assign o_PendingVec = pend_q;

endmodule

// File: tb/tb_vespa_intc_param.sv
// Self-checking bench for vespa_intc_param (NUM_SRC=8, SYNC_STAGES=2):
// reset checks, a table of steady level-mode vectors, hand-written
// handshake sequences, and a randomized run against a behavioural model.
module tb_vespa_intc_param;

    localparam int N = 8;
    localparam int S = 2;

    logic         clk = 1'b0;
    logic         rst;
    logic [N-1:0] src, en, em;
    logic         gen, att, comp;
    logic         o_req, o_ip;
    logic [2:0]   o_num;
    logic [N-1:0] o_pvec;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    vespa_intc_param #(.NUM_SRC(N), .SYNC_STAGES(S)) dut (
        .i_Clk            (clk),
        .i_Rst            (rst),
        .i_IntSources     (src),
        .i_GlobalEn       (gen),
        .i_SrcEn          (en),
        .i_EdgeMode       (em),
        .i_IntAckAttended (att),
        .i_IntAckComplete (comp),
        .o_IntReq         (o_req),
        .o_IntNumber      (o_num),
        .o_IntPending     (o_ip),
        .o_PendingVec     (o_pvec)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // ---------------- behavioural reference model ----------------
    logic [N-1:0] h [S+1];   // h[0] = most recently sampled input
    logic [N-1:0] m_pend;
    int           m_state;   // 0 idle, 1 requesting, 2 in service
    int           m_num, m_ptr;
    bit           m_req, m_ip;

    task automatic m_reset();
        for (int k = 0; k <= S; k++) h[k] = '0;
        m_pend = '0; m_state = 0; m_num = 0; m_ptr = 0; m_req = 0; m_ip = 0;
    endtask

    function automatic int pick(input logic [N-1:0] e, input int ptr);
        for (int k = 0; k < N; k++) begin
            int idx;
`ifdef VESPA_INTC_ROUND_ROBIN_EN
            idx = (ptr + k) % N;
`else
            idx = k;
`endif
            if (e[idx]) return idx;
        end
        return -1;
    endfunction

    task automatic m_step();
        logic [N-1:0] s, rise, elig, np;
        int w, ns, nn;
        bit nr, clr, any;
        s    = h[S-1];
        rise = s & ~h[S];
        elig = gen ? (m_pend & en) : '0;
        ns = m_state; nn = m_num; nr = m_req; clr = 0;
        case (m_state)
            0: begin
                w = pick(elig, m_ptr);
                if (w >= 0) begin ns = 1; nn = w; nr = 1; end
            end
            1: if (att) begin ns = 2; nr = 0; clr = 1; m_ptr = (m_num + 1) % N; end
            default: if (comp) ns = 0;
        endcase
        for (int i = 0; i < N; i++)
            np[i] = em[i] ? (rise[i] | (m_pend[i] & !(clr && m_num == i))) : s[i];
        any = 0;
        for (int i = 0; i < N; i++)
            if (elig[i] && i != nn) any = 1;
        m_ip = (ns != 0) && any;
        m_state = ns; m_num = nn; m_req = nr; m_pend = np;
        for (int k = S; k >= 1; k--) h[k] = h[k-1];
        h[0] = src;
    endtask

    task automatic do_reset();
        rst = 1'b1; src = '0; att = 1'b0; comp = 1'b0;
        tick();
        rst = 1'b0;
        m_reset();
    endtask

    task automatic pulse_att();
        att = 1'b1; tick(); att = 1'b0;
    endtask

    task automatic pulse_comp();
        comp = 1'b1; tick(); comp = 1'b0;
    endtask

    typedef struct {
        logic [N-1:0] src;
        logic [N-1:0] en;
        logic         gen;
        logic         exp_req;
        logic [2:0]   exp_num;
        logic         exp_ip;
    } vec_t;

    vec_t vecs [8];
    int   rr_exp [4];

    initial begin
        vecs[0] = '{8'h24, 8'hFF, 1'b1, 1'b1, 3'd2, 1'b1};
        vecs[1] = '{8'h80, 8'hFF, 1'b1, 1'b1, 3'd7, 1'b0};
        vecs[2] = '{8'h24, 8'hFB, 1'b1, 1'b1, 3'd5, 1'b0};
        vecs[3] = '{8'hFF, 8'hFF, 1'b0, 1'b0, 3'd0, 1'b0};
        vecs[4] = '{8'h00, 8'hFF, 1'b1, 1'b0, 3'd0, 1'b0};
        vecs[5] = '{8'h03, 8'h02, 1'b1, 1'b1, 3'd1, 1'b0};
        vecs[6] = '{8'h01, 8'h01, 1'b1, 1'b1, 3'd0, 1'b0};
        vecs[7] = '{8'hF0, 8'h00, 1'b1, 1'b0, 3'd0, 1'b0};
`ifdef VESPA_INTC_ROUND_ROBIN_EN
        rr_exp = '{0, 1, 0, 1};
`else
        rr_exp = '{0, 0, 0, 0};
`endif

        rst = 1'b1; src = '0; en = '1; em = '1; gen = 1'b1; att = 1'b0; comp = 1'b0;
        #1;
        chk("reset_req", o_req, 0);
        chk("reset_num", o_num, 0);
        chk("reset_ip", o_ip, 0);
        chk("reset_pvec", o_pvec, 0);
        tick();
        rst = 1'b0;
        m_reset();

        // Steady level-mode vectors.
        for (int r = 0; r < 8; r++) begin
            do_reset();
            em = '0; src = vecs[r].src; en = vecs[r].en; gen = vecs[r].gen;
            repeat (5) tick();
            chk($sformatf("vec%0d_req", r), o_req, vecs[r].exp_req);
            if (vecs[r].exp_req) chk($sformatf("vec%0d_num", r), o_num, vecs[r].exp_num);
            chk($sformatf("vec%0d_ip", r), o_ip, vecs[r].exp_ip);
            chk($sformatf("vec%0d_pvec", r), o_pvec, vecs[r].src);
        end
        en = '1; gen = 1'b1;

        // Edge on source 5: request on the 4th edge.
        do_reset();
        em = '1;
        src = 8'h20; tick(); src = '0;
        tick(); tick();
        chk("edge5_early_req", o_req, 0);
        tick();
        chk("edge5_req", o_req, 1);
        chk("edge5_num", o_num, 5);
        pulse_att();
        chk("edge5_att_req", o_req, 0);
        chk("edge5_att_num", o_num, 5);
        pulse_comp();
        tick(); tick();
        chk("edge5_idle_req", o_req, 0);
        chk("edge5_idle_pvec", o_pvec, 0);

        // Reset while requesting is asynchronous.
        do_reset();
        src = 8'h20; tick(); src = '0;
        repeat (3) tick();
        chk("rst_mid_pre_req", o_req, 1);
        rst = 1'b1;
        #1;
        chk("rst_mid_req", o_req, 0);
        chk("rst_mid_num", o_num, 0);
        chk("rst_mid_pvec", o_pvec, 0);
        tick();
        rst = 1'b0;

        // Simultaneous edges on 6 and 2.
        do_reset();
        src = 8'h44; tick(); src = '0;
        repeat (3) tick();
        chk("prio_req", o_req, 1);
        chk("prio_num", o_num, 2);
        chk("prio_ip", o_ip, 1);
        pulse_att();
        pulse_comp();
        tick();
        chk("prio_next_req", o_req, 1);
        chk("prio_next_num", o_num, 6);
        chk("prio_next_ip", o_ip, 0);

        // Level source 1 held through complete.
        do_reset();
        em = '0; src = 8'h02;
        repeat (4) tick();
        chk("lvl1_req", o_req, 1);
        chk("lvl1_num", o_num, 1);
        pulse_att();
        pulse_comp();
        chk("lvl1_gap_req", o_req, 0);
        tick();
        chk("lvl1_rereq", o_req, 1);
        chk("lvl1_renum", o_num, 1);
        do_reset();
        em = '0; src = 8'h02; en = 8'hFD;
        repeat (6) tick();
        chk("lvl1_dis_req", o_req, 0);
        en = '1;

        // Edge on 3 coinciding with attended for 3.
        do_reset();
        em = '1;
        src = 8'h08; tick(); src = '0;
        repeat (3) tick();
        chk("setdom_req", o_req, 1);
        chk("setdom_num", o_num, 3);
        src = 8'h08;
        tick(); tick();
        pulse_att();
        chk("setdom_att_req", o_req, 0);
        chk("setdom_pbit", o_pvec[3], 1);
        pulse_comp();
        tick();
        chk("setdom_rereq", o_req, 1);
        chk("setdom_renum", o_num, 3);
        src = '0;

        // Two level sources: service order.
        do_reset();
        em = '0; src = 8'h03;
        for (int n = 0; n < 4; n++) begin
            for (int t = 0; t < 10 && !o_req; t++) tick();
            chk($sformatf("order%0d_req", n), o_req, 1);
            chk($sformatf("order%0d_num", n), o_num, rr_exp[n]);
            pulse_att();
            pulse_comp();
        end

        // Randomized run against the model.
        do_reset();
        em = 8'($urandom);
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 2) == 0) src = src ^ (N'(1) << $urandom_range(0, N - 1));
            if ($urandom_range(0, 63) == 0) en = 8'($urandom) | 8'h81;
            if ($urandom_range(0, 255) == 0) em = 8'($urandom);
            gen  = ($urandom_range(0, 15) != 0);
            att  = ($urandom_range(0, 3) == 0);
            comp = ($urandom_range(0, 3) == 0);
            tick();
            m_step();
            chk("rnd_req", o_req, m_req);
            chk("rnd_num", o_num, m_num);
            chk("rnd_ip", o_ip, m_ip);
            chk("rnd_pvec", o_pvec, m_pend);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
